// File: rtl/obi_arb_pkg.sv
// Shared types and constants for the two-master OBI memory arbiter.
// Owner encoding, FSM states and the back-pressure LFSR seed.
package obi_arb_pkg;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } owner_t;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam logic [15:0] OBI_ARB_LFSR_SEED = 16'hACE1;

    function automatic owner_t other_owner(input owner_t o);
        return (o == M0) ? M1 : M0;
    endfunction

endpackage

// File: rtl/obi_arb_owner_fifo.sv
// Owner FIFO: records which master issued each granted request so that
// in-order memory responses can be routed back to the right master.
module obi_arb_owner_fifo
    import obi_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  owner_t push_owner_i,
    input  logic   pop_i,
    output logic   full_o,
    output logic   empty_o,
    output owner_t head_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    owner_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-2 depths would still be safe.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign head_o  = mem_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= ptr_inc(wptr_q);
            if (do_pop)  rptr_q <= ptr_inc(rptr_q);
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= push_owner_i;
    end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Round-robin arbiter sharing one OBI memory port between two masters.
// Define MEM_ARB_STALL_EN to add LFSR-driven random back-pressure in ARB.
module obi_mem_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    m0_req_i,
    output logic                    m0_gnt_o,
    output logic                    m0_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,

    input  logic                    m1_req_i,
    output logic                    m1_gnt_o,
    output logic                    m1_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,

    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,

    output logic                    err_o
);

    arb_state_e state_q;
    owner_t     rr_ptr_q;
    owner_t     lock_sel_q;
    owner_t     sel;
    owner_t     fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       handshake;
    logic       stall;

`ifdef MEM_ARB_STALL_EN
    logic [15:0] lfsr_q;

    // Fibonacci LFSR, taps 16/14/13/11; bit 0 injects idle cycles in ARB.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) lfsr_q <= OBI_ARB_LFSR_SEED;
        else         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // Once a request is presented it must stay stable until granted, so LOCK
    // ignores the FIFO-full and stall masks and keeps the frozen selection.
    always_comb begin
        sel       = lock_sel_q;
        mem_req_o = 1'b0;
        if (state_q == LOCK) begin
            mem_req_o = 1'b1;
        end else begin
            if (m0_req_i && m1_req_i) sel = rr_ptr_q;
            else if (m1_req_i)        sel = M1;
            else                      sel = M0;
            mem_req_o = (m0_req_i | m1_req_i) & ~fifo_full & ~stall;
        end
    end

    assign mem_addr_o  = (sel == M1) ? m1_addr_i  : m0_addr_i;
    assign mem_we_o    = (sel == M1) ? m1_we_i    : m0_we_i;
    assign mem_be_o    = (sel == M1) ? m1_be_i    : m0_be_i;
    assign mem_wdata_o = (sel == M1) ? m1_wdata_i : m0_wdata_i;

    assign handshake = mem_req_o & mem_gnt_i;
    assign m0_gnt_o  = handshake & (sel == M0);
    assign m1_gnt_o  = handshake & (sel == M1);

    assign m0_rvalid_o = mem_rvalid_i & ~fifo_empty & (fifo_head == M0);
    assign m1_rvalid_o = mem_rvalid_i & ~fifo_empty & (fifo_head == M1);
    assign m0_rdata_o  = mem_rdata_i;
    assign m1_rdata_o  = mem_rdata_i;

    obi_arb_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (handshake),
        .push_owner_i (sel),
        .pop_i        (mem_rvalid_i),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .head_o       (fifo_head)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ARB;
            lock_sel_q <= M0;
            rr_ptr_q   <= M0;
            err_o      <= 1'b0;
        end else begin
            if (handshake)                  rr_ptr_q <= other_owner(sel);
            if (mem_rvalid_i && fifo_empty) err_o    <= 1'b1;
            case (state_q)
                ARB: begin
                    if (mem_req_o && !mem_gnt_i) begin
                        state_q    <= LOCK;
                        lock_sel_q <= sel;
                    end
                end
                LOCK: begin
                    if (mem_gnt_i) state_q <= ARB;
                end
                default: state_q <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Scoreboard bench for obi_mem_arbiter: directed contention scenarios, with a
// randomised back-pressure run when MEM_ARB_STALL_EN is defined.
module tb_obi_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        m0_req_i = 1'b0, m1_req_i = 1'b0;
    logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_addr_i = '0, m1_addr_i = '0;
    logic        m0_we_i = 1'b0, m1_we_i = 1'b0;
    logic [3:0]  m0_be_i = '0, m1_be_i = '0;
    logic [31:0] m0_wdata_i = '0, m1_wdata_i = '0;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        mem_req_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        err_o;

    obi_mem_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i (clk), .rst_ni (rst_ni),
        .m0_req_i (m0_req_i), .m0_gnt_o (m0_gnt_o), .m0_rvalid_o (m0_rvalid_o),
        .m0_addr_i (m0_addr_i), .m0_we_i (m0_we_i), .m0_be_i (m0_be_i),
        .m0_wdata_i (m0_wdata_i), .m0_rdata_o (m0_rdata_o),
        .m1_req_i (m1_req_i), .m1_gnt_o (m1_gnt_o), .m1_rvalid_o (m1_rvalid_o),
        .m1_addr_i (m1_addr_i), .m1_we_i (m1_we_i), .m1_be_i (m1_be_i),
        .m1_wdata_i (m1_wdata_i), .m1_rdata_o (m1_rdata_o),
        .mem_req_o (mem_req_o), .mem_gnt_i (mem_gnt_i), .mem_rvalid_i (mem_rvalid_i),
        .mem_addr_o (mem_addr_o), .mem_we_o (mem_we_o), .mem_be_o (mem_be_o),
        .mem_wdata_o (mem_wdata_o), .mem_rdata_i (mem_rdata_i),
        .err_o (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] q0[$], q1[$];        // pending master requests (head is on the bus)
    logic [31:0] exp0[$], exp1[$];    // expected read data per master, in order
    logic [31:0] accq[$];             // memory model: accepted, not yet answered
    logic        mem_hold = 1'b0;
    int          rv_credit = 0;

    logic        s_g0, s_g1, s_rv0, s_rv1, s_req, s_mg, s_err, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;
    logic        prev_stalled = 1'b0;
    logic [31:0] prev_addr = '0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] wdata_of(input logic [31:0] a);
        return ~a;
    endfunction
    function automatic logic we_of(input logic [31:0] a);
        return a[3];
    endfunction
    function automatic logic [3:0] be_of(input logic [31:0] a);
        return ~a[3:0];
    endfunction

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    // Monitor: every response is matched against the per-master scoreboard.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (m0_rvalid_o && m1_rvalid_o) fail_event("both_rvalid");
            if (m0_rvalid_o) begin
                if (exp0.size() == 0) fail_event("m0_unexpected_rvalid");
                else check_word("m0_rdata", m0_rdata_o, exp0.pop_front());
            end
            if (m1_rvalid_o) begin
                if (exp1.size() == 0) fail_event("m1_unexpected_rvalid");
                else check_word("m1_rdata", m1_rdata_o, exp1.pop_front());
            end
        end
    end

    task automatic drive_reqs();
        m0_req_i   = (q0.size() > 0);
        m0_addr_i  = m0_req_i ? q0[0] : '0;
        m0_we_i    = m0_req_i ? we_of(m0_addr_i) : 1'b0;
        m0_be_i    = m0_req_i ? be_of(m0_addr_i) : '0;
        m0_wdata_i = m0_req_i ? wdata_of(m0_addr_i) : '0;
        m1_req_i   = (q1.size() > 0);
        m1_addr_i  = m1_req_i ? q1[0] : '0;
        m1_we_i    = m1_req_i ? we_of(m1_addr_i) : 1'b0;
        m1_be_i    = m1_req_i ? be_of(m1_addr_i) : '0;
        m1_wdata_i = m1_req_i ? wdata_of(m1_addr_i) : '0;
    endtask

    task automatic check_grant(input string who, inout logic [31:0] q[$]);
        logic [31:0] a;
        if (q.size() == 0) begin
            fail_event({who, "_unexpected_gnt"});
        end else begin
            a = q.pop_front();
            check_word({who, "_gnt_addr"}, s_addr, a);
            check_word({who, "_gnt_wdata"}, s_wdata, wdata_of(a));
            check_bit({who, "_gnt_we"}, s_we, we_of(a));
            check_word({who, "_gnt_be"}, {28'b0, s_be}, {28'b0, be_of(a)});
        end
    endtask

    // One clock: sample at negedge, then update masters and memory model.
    task automatic tick();
        @(negedge clk);
        s_g0 = m0_gnt_o;  s_g1 = m1_gnt_o;  s_rv0 = m0_rvalid_o; s_rv1 = m1_rvalid_o;
        s_req = mem_req_o; s_mg = mem_gnt_i; s_err = err_o;
        s_addr = mem_addr_o; s_wdata = mem_wdata_o; s_we = mem_we_o; s_be = mem_be_o;
        if (rst_ni) begin
            if (prev_stalled) begin
                check_bit("lock_req_held", s_req, 1'b1);
                check_word("lock_addr_held", s_addr, prev_addr);
            end
            prev_stalled = s_req & ~s_mg;
            prev_addr    = s_addr;
        end else begin
            prev_stalled = 1'b0;
        end
        @(posedge clk);
        #1;
        if (rst_ni) begin
            if (s_g0 && s_g1) fail_event("both_gnt");
            if (s_g0) check_grant("m0", q0);
            if (s_g1) check_grant("m1", q1);
            if (s_req && s_mg) accq.push_back(s_addr);
        end
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        if (accq.size() > 0 && (!mem_hold || rv_credit > 0)) begin
            if (mem_hold) rv_credit--;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem_data(accq.pop_front());
        end
        drive_reqs();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q0.size() + q1.size() + accq.size() + exp0.size() + exp1.size()) != 0 && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: got pending traffic after %0d cycles, expected idle", name, n);
        end
        repeat (2) tick();
    endtask

    task automatic do_reset();
        rst_ni    = 1'b0;
        mem_gnt_i = 1'b0;
        mem_hold  = 1'b0;
        rv_credit = 0;
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic push_req(input bit m1, input logic [31:0] a);
        if (m1) begin q1.push_back(a); exp1.push_back(mem_data(a)); end
        else    begin q0.push_back(a); exp0.push_back(mem_data(a)); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] e_g0, e_g1, e_rv0, e_rv1;

        // Reset state
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
        check_bit("rst_m0_gnt", s_g0, 1'b0);
        check_bit("rst_m1_gnt", s_g1, 1'b0);
        check_bit("rst_m0_rvalid", s_rv0, 1'b0);
        check_bit("rst_m1_rvalid", s_rv1, 1'b0);
        check_bit("rst_mem_req", s_req, 1'b0);
        check_bit("rst_err", s_err, 1'b0);

        // 1: m0 alone, grant same cycle, response next cycle
        mem_gnt_i = 1'b1;
        push_req(1'b0, 32'h0000_0800);
        drive_reqs();
        tick();
        check_bit("t1_c0_m0_gnt", s_g0, 1'b1);
        check_bit("t1_c0_m1_gnt", s_g1, 1'b0);
        check_word("t1_c0_addr", s_addr, 32'h0000_0800);
        check_bit("t1_c0_m0_rvalid", s_rv0, 1'b0);
        tick();
        check_bit("t1_c1_m0_rvalid", s_rv0, 1'b1);
        check_bit("t1_c1_m1_rvalid", s_rv1, 1'b0);
        check_bit("t1_c1_m0_gnt", s_g0, 1'b0);
        drain("t1");

        // 2: both request, continuous grant -> strict alternation starting at m0
        do_reset();
        mem_gnt_i = 1'b1;
        push_req(1'b0, 32'h0000_1000);
        push_req(1'b0, 32'h0000_1008);
        push_req(1'b1, 32'h0000_2000);
        push_req(1'b1, 32'h0000_2008);
        drive_reqs();
        e_g0 = 5'b00101; e_g1 = 5'b01010; e_rv0 = 5'b01010; e_rv1 = 5'b10100;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_bit($sformatf("t2_c%0d_m0_gnt", i), s_g0, e_g0[i]);
            check_bit($sformatf("t2_c%0d_m1_gnt", i), s_g1, e_g1[i]);
            check_bit($sformatf("t2_c%0d_m0_rvalid", i), s_rv0, e_rv0[i]);
            check_bit($sformatf("t2_c%0d_m1_rvalid", i), s_rv1, e_rv1[i]);
        end
        drain("t2");

        // 3: m1 stalled by memory for 3 cycles, m0 arrives during the stall
        do_reset();
        push_req(1'b1, 32'h0000_3000);
        drive_reqs();
        tick();
        check_word("t3_c0_addr", s_addr, 32'h0000_3000);
        check_bit("t3_c0_req", s_req, 1'b1);
        push_req(1'b0, 32'h0000_3100);
        drive_reqs();
        for (int i = 1; i < 3; i++) begin
            tick();
            check_word($sformatf("t3_c%0d_addr", i), s_addr, 32'h0000_3000);
            check_bit($sformatf("t3_c%0d_m0_gnt", i), s_g0, 1'b0);
        end
        mem_gnt_i = 1'b1;
        tick();
        check_word("t3_c3_addr", s_addr, 32'h0000_3000);
        check_bit("t3_c3_m1_gnt", s_g1, 1'b1);
        check_bit("t3_c3_m0_gnt", s_g0, 1'b0);
        tick();
        check_bit("t3_c4_m0_gnt", s_g0, 1'b1);
        check_word("t3_c4_addr", s_addr, 32'h0000_3100);
        drain("t3");

        // 4: responses withheld -> two grants, then request masked while full
        do_reset();
        mem_gnt_i = 1'b1;
        mem_hold  = 1'b1;
        push_req(1'b0, 32'h0000_4000);
        push_req(1'b0, 32'h0000_4008);
        push_req(1'b1, 32'h0000_5000);
        push_req(1'b1, 32'h0000_5008);
        drive_reqs();
        tick(); check_bit("t4_c0_m0_gnt", s_g0, 1'b1);
        tick(); check_bit("t4_c1_m1_gnt", s_g1, 1'b1);
        tick(); check_bit("t4_c2_req", s_req, 1'b0);
        rv_credit = 1;
        tick(); check_bit("t4_c3_req", s_req, 1'b0);
        tick();
        check_bit("t4_c4_req_full_pop", s_req, 1'b0);
        check_bit("t4_c4_m0_rvalid", s_rv0, 1'b1);
        tick();
        check_bit("t4_c5_m0_gnt", s_g0, 1'b1);
        mem_hold = 1'b0;
        tick(); check_bit("t4_c6_req", s_req, 1'b0);
        tick();
        check_bit("t4_c7_req_full_pop", s_req, 1'b0);
        check_bit("t4_c7_m1_rvalid", s_rv1, 1'b1);
        tick();
        check_bit("t4_c8_m1_gnt", s_g1, 1'b1);
        check_bit("t4_c8_m0_rvalid", s_rv0, 1'b1);
        tick();
        check_bit("t4_c9_m1_rvalid", s_rv1, 1'b1);
        drain("t4");

        // 5: orphan response sets the sticky error until reset
        do_reset();
        tick();
        check_bit("t5_err_before", s_err, 1'b0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1234_5678;
        tick();
        check_bit("t5_pulse_m0_rvalid", s_rv0, 1'b0);
        check_bit("t5_pulse_m1_rvalid", s_rv1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_bit($sformatf("t5_err_sticky%0d", i), s_err, 1'b1);
        end
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        check_bit("t5_err_cleared", s_err, 1'b0);

`ifdef MEM_ARB_STALL_EN
        // 6: random grant/response back-pressure on top of the LFSR stalls
        do_reset();
        for (int i = 0; i < 500; i++) begin
            push_req(1'b0, 32'h0006_0000 + 32'(i * 8));
            push_req(1'b1, 32'h0007_0000 + 32'(i * 8));
        end
        drive_reqs();
        for (int n = 0; n < 20000 && (q0.size() + q1.size() + accq.size() + exp0.size() + exp1.size()) != 0; n++) begin
            mem_gnt_i = ($urandom_range(0, 3) != 0);
            mem_hold  = ($urandom_range(0, 3) == 0);
            tick();
        end
        mem_gnt_i = 1'b1;
        mem_hold  = 1'b0;
        drain("t6");
        check_bit("t6_err_clear", s_err, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
